// File: rtl/mop_seq_accumulator_if.sv
// rtl/mop_seq_accumulator_if.sv - operand-in / sum-out handshake bundle for the sequential accumulator
interface mop_seq_accumulator_if #(
  parameter int N = 4,
  parameter int K = 4
);
  localparam int W = N + $clog2(K);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, busy
  );
endinterface

// File: rtl/mop_seq_accumulator.sv
// rtl/mop_seq_accumulator.sv - folds K unsigned N-bit operands into one full-precision sum
module mop_seq_accumulator #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mop_seq_accumulator_if.slave   bus
);
  localparam int W  = N + $clog2(K);
  localparam int CW = $clog2(K);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   out_sum_q, out_sum_d;
  logic           out_valid_q, out_valid_d;
  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;

  logic [W-1:0]   addend;
  logic [W-1:0]   sum;
  logic           in_xfer;
  logic           out_xfer;

  // Explicit ripple-carry chain, carry-in 0; W leaves headroom so carry-out is always 0.
  always_comb begin
    logic carry;
    addend = {{(W-N){1'b0}}, bus.in_data};
    sum    = '0;
    carry  = 1'b0;
    for (int i = 0; i < W; i++) begin
      sum[i] = acc_q[i] ^ addend[i] ^ carry;
      carry  = (acc_q[i] & addend[i]) | (carry & (acc_q[i] ^ addend[i]));
    end
  end

  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          acc_d   = sum;
          cnt_d   = CW'(1);
          busy_d  = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        if (in_xfer) begin
          if (cnt_q == CW'(K-1)) begin
            out_sum_d   = sum;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = HOLD;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        // out_sum is left untouched so the last result stays readable.
        if (out_xfer) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = in_ready_q;
    bus.out_valid = out_valid_q;
    bus.out_sum   = out_sum_q;
    bus.busy      = busy_q;
  end
endmodule
